// File: rtl/countdown_display_timer.sv
// MM:SS BCD countdown engine driven by an external one-second tick.
// Optional low-time warning output is built only when COUNTDOWN_WARN_EN is defined.
module countdown_display_timer #(
  parameter logic [15:0] RESET_DIGITS = 16'h0100,
  parameter int          WARN_SECONDS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        one_second_pulse,
  input  logic        load,
  input  logic [15:0] load_digits,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] digits,
  output logic        running,
  output logic        expired,
  output logic        done_pulse,
  output logic        load_err,
  output logic        warn
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  if ((WARN_SECONDS < 0) || (WARN_SECONDS > 59)) begin : g_warn_range
    $error("WARN_SECONDS must be within 0..59");
  end

  function automatic logic bcd_valid(input logic [15:0] d);
    return (d[15:12] <= 4'd9) && (d[11:8] <= 4'd9) &&
           (d[7:4] <= 4'd5) && (d[3:0] <= 4'd9);
  endfunction

  // Borrow ripples s1 -> s10 (mod 6) -> m1 -> m10; caller guarantees d != 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (d[3:0] != 4'd0) begin
      r[3:0] = d[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (d[7:4] != 4'd0) begin
        r[7:4] = d[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (d[11:8] != 4'd0) begin
          r[11:8] = d[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = d[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] digits_r, digits_s, dec_s;
  logic        running_r, expired_r, done_r, done_s, load_err_r, load_err_s;
  logic        warn_r, warn_s;

  // Next-state and next-digits selection with load > start > pause > tick priority.
  always_comb begin
    state_s    = state_r;
    digits_s   = digits_r;
    done_s     = 1'b0;
    load_err_s = 1'b0;
    dec_s      = bcd_dec(digits_r);
    if (load) begin
      if (bcd_valid(load_digits)) begin
        digits_s = load_digits;
        state_s  = ST_IDLE;
      end else begin
        load_err_s = 1'b1;
      end
    end else if (start) begin
      case (state_r)
        ST_IDLE, ST_PAUSED: begin
          if (digits_r != 16'h0000) begin
            state_s = ST_RUNNING;
          end else begin
            state_s = state_r;
          end
        end
        default: state_s = state_r;
      endcase
    end else if (pause) begin
      if (state_r == ST_RUNNING) begin
        state_s = ST_PAUSED;
      end else begin
        state_s = state_r;
      end
    end else if (one_second_pulse && (state_r == ST_RUNNING)) begin
      digits_s = dec_s;
      if (dec_s == 16'h0000) begin
        state_s = ST_EXPIRED;
        done_s  = 1'b1;
      end else begin
        state_s = ST_RUNNING;
      end
    end else begin
      state_s = state_r;
    end
  end

`ifdef COUNTDOWN_WARN_EN
  logic [6:0] secs_s;

  // Warning window evaluated on the next digits so it lines up with the digit update.
  always_comb begin
    secs_s = ({3'd0, digits_s[7:4]} * 7'd10) + {3'd0, digits_s[3:0]};
    if (((state_s == ST_RUNNING) || (state_s == ST_PAUSED)) &&
        (digits_s[15:8] == 8'h00) && (secs_s != 7'd0) &&
        (secs_s <= 7'(WARN_SECONDS))) begin
      warn_s = 1'b1;
    end else begin
      warn_s = 1'b0;
    end
  end
`else
  assign warn_s = 1'b0;
`endif

  // State, digits and all flag outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      digits_r   <= RESET_DIGITS;
      running_r  <= 1'b0;
      expired_r  <= 1'b0;
      done_r     <= 1'b0;
      load_err_r <= 1'b0;
      warn_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      digits_r   <= digits_s;
      running_r  <= (state_s == ST_RUNNING);
      expired_r  <= (state_s == ST_EXPIRED);
      done_r     <= done_s;
      load_err_r <= load_err_s;
      warn_r     <= warn_s;
    end
  end

  assign digits     = digits_r;
  assign running    = running_r;
  assign expired    = expired_r;
  assign done_pulse = done_r;
  assign load_err   = load_err_r;
  assign warn       = warn_r;

endmodule

// File: tb/tb_countdown_display_timer.sv
// Self-checking bench for countdown_display_timer: per-cycle scoreboard fed by a
// seconds-count reference model, plus direct checks of the documented scenarios.
module tb_countdown_display_timer;

  localparam int WARN = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [15:0] load_digits = 16'h0000;
  logic [15:0] digits;
  logic        running, expired, done_pulse, load_err, warn;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        run;
    logic        exp;
    logic        done;
    logic        err;
    logic        wrn;
  } exp_t;
  exp_t sb[$];

  // model: 0 idle, 1 running, 2 paused, 3 expired; time kept as plain seconds
  int m_state = 0;
  int m_secs = 60;

  countdown_display_timer #(.RESET_DIGITS(16'h0100), .WARN_SECONDS(WARN)) dut (
    .clk(clk), .rst_n(rst_n), .one_second_pulse(tick), .load(load),
    .load_digits(load_digits), .start(start), .pause(pause), .digits(digits),
    .running(running), .expired(expired), .done_pulse(done_pulse),
    .load_err(load_err), .warn(warn)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // One clock: drive inputs, predict via model, push expectation, pop and compare.
  task automatic cyc(input logic ld, input logic [15:0] ldd, input logic st,
                     input logic ps, input logic tk);
    exp_t e, got;
    logic err_e, done_e, wrn_e;
    @(negedge clk);
    load = ld; load_digits = ldd; start = st; pause = ps; tick = tk;
    err_e = 1'b0; done_e = 1'b0;
    if (ld) begin
      if (ldd[15:12] <= 4'd9 && ldd[11:8] <= 4'd9 && ldd[7:4] <= 4'd5 && ldd[3:0] <= 4'd9) begin
        m_secs = int'(ldd[15:12]) * 600 + int'(ldd[11:8]) * 60 + int'(ldd[7:4]) * 10 + int'(ldd[3:0]);
        m_state = 0;
      end else err_e = 1'b1;
    end else if (st) begin
      if ((m_state == 0 || m_state == 2) && m_secs != 0) m_state = 1;
    end else if (ps) begin
      if (m_state == 1) m_state = 2;
    end else if (tk && m_state == 1) begin
      m_secs = m_secs - 1;
      if (m_secs == 0) begin m_state = 3; done_e = 1'b1; end
    end
`ifdef COUNTDOWN_WARN_EN
    wrn_e = (m_state == 1 || m_state == 2) && m_secs > 0 && m_secs <= WARN;
`else
    wrn_e = 1'b0;
`endif
    e = '{d: to_bcd(m_secs), run: (m_state == 1), exp: (m_state == 3),
          done: done_e, err: err_e, wrn: wrn_e};
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = '{d: digits, run: running, exp: expired, done: done_pulse, err: load_err, wrn: warn};
    if (done_pulse === 1'b1) done_seen++;
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL cycle_outputs at %0t: got d=%h run=%b exp=%b done=%b err=%b warn=%b, want d=%h run=%b exp=%b done=%b err=%b warn=%b",
               $time, got.d, got.run, got.exp, got.done, got.err, got.wrn,
               e.d, e.run, e.exp, e.done, e.err, e.wrn);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #35;
    checks++;
    if ({digits, running, expired, done_pulse, load_err, warn} !== {16'h0100, 5'b00000}) begin
      errors++;
      $display("FAIL reset_state: got %h/%b%b%b%b%b, want 0100/00000",
               digits, running, expired, done_pulse, load_err, warn);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_state = 0; m_secs = 60;
    idle(1);
  endtask

  task automatic test_countdown;
    done_seen = 0;
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);  // tick with start is not counted
    for (int i = 0; i < 60; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (digits !== 16'h0000 || expired !== 1'b1) begin
      errors++;
      $display("FAIL countdown_expiry: got d=%h expired=%b, want 0000/1", digits, expired);
    end
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);  // start and tick in EXPIRED ignored
    idle(2);
    checks++;
    if (done_seen != 1) begin
      errors++;
      $display("FAIL done_pulse_count: got %0d, want 1", done_seen);
    end
  endtask

  task automatic test_borrow;
    cyc(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (digits !== 16'h0959) begin
      errors++;
      $display("FAIL borrow_minutes: got %h, want 0959", digits);
    end
    cyc(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (digits !== 16'h0009) begin
      errors++;
      $display("FAIL borrow_seconds: got %h, want 0009", digits);
    end
    cyc(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (digits !== 16'h0059) begin
      errors++;
      $display("FAIL borrow_tens: got %h, want 0059", digits);
    end
  endtask

  task automatic test_invalid_load;
    cyc(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0060, 1'b0, 1'b0, 1'b0);
    checks++;
    if (load_err !== 1'b1 || digits !== 16'h0100) begin
      errors++;
      $display("FAIL invalid_load_s10: got err=%b d=%h, want 1/0100", load_err, digits);
    end
    cyc(1'b1, 16'h0A00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (load_err !== 1'b1 || digits !== 16'h0100) begin
      errors++;
      $display("FAIL invalid_load_m1: got err=%b d=%h, want 1/0100", load_err, digits);
    end
    idle(1);
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_err_pulse: got %b, want 0", load_err);
    end
  endtask

  task automatic test_pause_resume;
    cyc(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (digits !== 16'h0003 || running !== 1'b0) begin
      errors++;
      $display("FAIL paused_hold: got d=%h run=%b, want 0003/0", digits, running);
    end
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (expired !== 1'b1 || done_pulse !== 1'b1) begin
      errors++;
      $display("FAIL resume_expiry: got exp=%b done=%b, want 1/1", expired, done_pulse);
    end
  endtask

  task automatic test_simultaneous;
    cyc(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    checks++;
    if (digits !== 16'h0005) begin
      errors++;
      $display("FAIL pause_with_tick: got %h, want 0005", digits);
    end
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0030, 1'b0, 1'b0, 1'b1);
    checks++;
    if (digits !== 16'h0030 || running !== 1'b0) begin
      errors++;
      $display("FAIL load_with_tick: got d=%h run=%b, want 0030/0", digits, running);
    end
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    checks++;
    if (running !== 1'b0 || expired !== 1'b0) begin
      errors++;
      $display("FAIL start_at_zero: got run=%b exp=%b, want 0/0", running, expired);
    end
  endtask

  task automatic test_warn;
    logic w_at_10;
`ifdef COUNTDOWN_WARN_EN
    w_at_10 = 1'b1;
`else
    w_at_10 = 1'b0;
`endif
    cyc(1'b1, 16'h0012, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (warn !== 1'b0) begin
      errors++;
      $display("FAIL warn_at_11: got %b, want 0", warn);
    end
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (warn !== w_at_10) begin
      errors++;
      $display("FAIL warn_at_10: got %b, want %b", warn, w_at_10);
    end
    repeat (10) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);  // back-to-back ticks
    checks++;
    if (warn !== 1'b0 || expired !== 1'b1) begin
      errors++;
      $display("FAIL warn_at_expiry: got warn=%b exp=%b, want 0/1", warn, expired);
    end
  endtask

  task automatic test_reset_mid;
    cyc(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (digits !== 16'h0100 || running !== 1'b0 || done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_count: got d=%h run=%b done=%b, want 0100/0/0",
               digits, running, done_pulse);
    end
    @(negedge clk);
    tick = 1'b0;
    rst_n = 1'b1;
    m_state = 0; m_secs = 60;
    idle(2);
  endtask

  initial begin
    test_reset;
    test_countdown;
    test_borrow;
    test_invalid_load;
    test_pause_resume;
    test_simultaneous;
    test_warn;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_display_timer.md
# countdown_display_timer

Seconds-resolution countdown engine downstream of the one-second pulse generator. Holds remaining time as four BCD digits (MM:SS, max 99:59), decrements once per incoming `one_second_pulse` while running, and flags expiry. BCD digits feed the seven-segment decoder stage directly; `expired`/`done_pulse` feed game/alarm control logic.

## Interface
- `RESET_DIGITS`, default 16'h0100: BCD {m10,m1,s10,s1} loaded at reset (01:00).
- `WARN_SECONDS`, default 10: warning threshold in seconds, legal 0..59 (used only with `COUNTDOWN_WARN_EN`).

- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `one_second_pulse`  in  1  single-cycle tick from upstream divider.
- `load`  in  1  load `load_digits`, go IDLE.
- `load_digits`  in  16  BCD {m10[15:12], m1[11:8], s10[7:4], s1[3:0]}.
- `start`  in  1  begin/resume counting.
- `pause`  in  1  suspend counting.
- `digits`  out  16  remaining time, BCD, same packing as `load_digits`.
- `running`  out  1  high in RUNNING.
- `expired`  out  1  high in EXPIRED.
- `done_pulse`  out  1  one-cycle pulse on reaching 00:00.
- `load_err`  out  1  one-cycle pulse on rejected load.
- `warn`  out  1  low-time warning (tied 0 without macro).

## Operation
- States: IDLE, RUNNING, PAUSED, EXPIRED. All outputs registered.
- Control priority per cycle: `load` > `start` > `pause` > tick.
- `load` (any state): valid if every digit ≤ 9 and s10 ≤ 5. Valid → `digits` <= `load_digits`, state IDLE. Invalid → `digits` and state unchanged, `load_err` = 1 next cycle.
- `start`: IDLE/PAUSED → RUNNING if `digits` ≠ 00:00; at 00:00 ignored. Ignored in RUNNING and EXPIRED.
- `pause`: RUNNING → PAUSED; ignored elsewhere.
- Tick in RUNNING: decrement with BCD borrow: s1 0→9 borrows s10; s10 0→5 borrows m1; m1 0→9 borrows m10. Examples: 00:10→00:09, 01:00→00:59, 10:00→09:59.
- Decrement producing 00:00: same edge state → EXPIRED, `done_pulse` = 1 for that cycle only.
- EXPIRED: `digits` held at 00:00; exited only by `load` or reset.
- Ticks outside RUNNING ignored, not queued.

## Timing
- Reset (async assert, sync to `clk` deassert by upstream): `digits` = `RESET_DIGITS`, state IDLE, `running`/`expired`/`done_pulse`/`load_err`/`warn` = 0.
- Tick sampled at edge N → `digits` updated after edge N (1-cycle latency); `expired`, `done_pulse` valid on same edge as final digits.
- `start` at edge N → `running` = 1 after edge N; tick coincident with `start` is not counted.
- `pause` coincident with tick → no decrement.
- `load` coincident with tick in RUNNING → load wins, tick dropped.
- Reset mid-count discards state immediately; no `done_pulse`.
- Back-to-back ticks (every cycle) supported; each decrements once.

## Configuration
- `COUNTDOWN_WARN_EN` defined: `warn` = 1 (registered, same cycle as `digits`) when state is RUNNING or PAUSED, m10 = m1 = 0, and 10·s10 + s1 ≤ `WARN_SECONDS` and ≠ 0; otherwise 0.
- Undefined: warn logic not built, `warn` tied 0.

## Test plan
- Reset release: `digits` = 16'h0100, all flags 0; `start`, 60 ticks → `digits` 16'h0000, `expired` = 1, `done_pulse` exactly one cycle.
- Borrow chain: load 16'h1000, start, one tick → 16'h0959; load 16'h0010, tick → 16'h0009.
- Invalid load: load 16'h0060 from 16'h0100 → `load_err` pulse, `digits` stays 16'h0100; load 16'h0A00 likewise.
- Pause/resume: run from 16'h0005, pause after 2 ticks (16'h0003), 5 ticks while paused → 16'h0003; start, 3 ticks → expired.
- Simultaneous events: `pause`+tick same cycle → no decrement; `load` 16'h0030 + tick in RUNNING → 16'h0030, IDLE; `start` at 00:00 → stays IDLE.
- With `COUNTDOWN_WARN_EN`, WARN_SECONDS = 10: from 16'h0012, `warn` 0 at 00:11, 1 at 00:10 through 00:01, 0 at 00:00/EXPIRED; without macro `warn` constant 0.
